// File: rtl/uart_apb_regs_if.sv
// rtl/uart_apb_regs_if.sv - APB3 bus bundle between the system fabric and uart_apb_regs
//
// Signals:
//   psel, penable, pwrite   APB3 transfer control (master -> slave)
//   paddr [ADDR_W-1:0]      byte address, bits [1:0] ignored by the slave
//   pwdata [31:0]           write data (master -> slave)
//   prdata [31:0]           read data, non-zero only while pready is high (slave -> master)
//   pready, pslverr         transfer completion and error (slave -> master)
interface uart_apb_regs_if #(
    parameter int ADDR_W = 4
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        input  prdata,
        input  pready,
        input  pslverr
    );

    modport slave (
        input  psel,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        output prdata,
        output pready,
        output pslverr
    );
endinterface

// File: rtl/uart_apb_regs.sv
// rtl/uart_apb_regs.sv - APB3 register block bridging the host bus to uart_core
//
// Optional feature macro: UART_APB_PSLVERR_EN
//   defined   : pslverr flags unmapped addresses, RXDATA writes and dropped TXDATA writes
//   undefined : pslverr is held low and such accesses complete silently
//
// Ports:
//   clk               system clock
//   rst               synchronous active-high reset
//   apb               APB3 slave modport (psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr)
//   tx_data_o         data word handed to the core transmitter
//   start_tx_o        one-cycle transmit start pulse
//   tx_done_i         one-cycle pulse from the core at end of a transmitted frame
//   rx_data_i         received word from the core
//   rx_done_i         one-cycle pulse from the core when a frame has been received
//   parity_error_i    parity status, qualified by rx_done_i
//   host_read_data_o  one-cycle pulse when the host has consumed the received word
//   data_bit_num_o    CFG[1:0]
//   parity_en_o       CFG[2]
//   parity_type_o     CFG[3]
//   stop_bit_num_o    CFG[4]
//   irq_o             registered level interrupt
//
// Register map (word offsets):
//   0x0 TXDATA  W   start a transmission when the transmitter is free
//   0x4 RXDATA  R   last received word; reading it consumes rx_valid
//   0x8 CFG     RW  [4:0] frame config, [5] tx_ie, [6] rx_ie
//   0xC STATUS      [0] tx_busy, [1] rx_valid, [2] PERR, [3] OVERRUN, [4] TXDROP (bits 2..4 W1C)
module uart_apb_regs #(
    parameter int         ADDR_W  = 4,
    parameter logic [4:0] CFG_RST = 5'b00011
) (
    input  logic           clk,
    input  logic           rst,
    uart_apb_regs_if.slave apb,
    output logic [31:0]    tx_data_o,
    output logic           start_tx_o,
    input  logic           tx_done_i,
    input  logic [31:0]    rx_data_i,
    input  logic           rx_done_i,
    input  logic           parity_error_i,
    output logic           host_read_data_o,
    output logic [1:0]     data_bit_num_o,
    output logic           parity_en_o,
    output logic           parity_type_o,
    output logic           stop_bit_num_o,
    output logic           irq_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Local views of the bus inputs.
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;

    assign psel    = apb.psel;
    assign penable = apb.penable;
    assign pwrite  = apb.pwrite;
    assign paddr   = apb.paddr;
    assign pwdata  = apb.pwdata;

    // Register state.
    logic        tx_busy;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        perr;
    logic        overrun;
    logic        txdrop;
    logic [4:0]  cfg;
    logic [1:0]  ie;          // {rx_ie, tx_ie}

    // Address decode. Byte address bits [1:0] are dropped; anything past the
    // four words is unmapped (only reachable when ADDR_W > 4).
    logic [31:0] word_idx;
    logic        addr_mapped;
    logic        sel_tx;
    logic        sel_rx;
    logic        sel_cfg;
    logic        sel_st;

    assign word_idx    = 32'(paddr) >> 2;
    assign addr_mapped = (word_idx < 32'd4);
    assign sel_tx      = addr_mapped && (word_idx[1:0] == 2'd0);
    assign sel_rx      = addr_mapped && (word_idx[1:0] == 2'd1);
    assign sel_cfg     = addr_mapped && (word_idx[1:0] == 2'd2);
    assign sel_st      = addr_mapped && (word_idx[1:0] == 2'd3);

    // Access strobes, all qualified by the DONE cycle from the FSM below.
    logic commit;
    logic wr_commit;
    logic rd_commit;
    logic tx_accept;
    logic tx_drop;
    logic rx_consume;
    logic cfg_wr;
    logic st_wr;
    logic bad_access;

    assign wr_commit  = commit && pwrite;
    assign rd_commit  = commit && !pwrite;
    // A tx_done_i arriving in the same cycle frees the transmitter just in time.
    assign tx_accept  = wr_commit && sel_tx && (!tx_busy || tx_done_i);
    assign tx_drop    = wr_commit && sel_tx && tx_busy && !tx_done_i;
    assign rx_consume = rd_commit && sel_rx && rx_valid;
    assign cfg_wr     = wr_commit && sel_cfg;
    assign st_wr      = wr_commit && sel_st;

`ifdef UART_APB_PSLVERR_EN
    assign bad_access = !addr_mapped || (pwrite && sel_rx) || tx_drop;
`else
    assign bad_access = 1'b0;
`endif

    // Read mux; TXDATA and unmapped addresses read as zero.
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        if (sel_rx) begin
            rd_mux = rx_data;
        end else if (sel_cfg) begin
            rd_mux = {25'd0, ie, cfg};
        end else if (sel_st) begin
            rd_mux = {27'd0, txdrop, overrun, perr, rx_valid, tx_busy};
        end
    end

    // APB FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // APB FSM: next state and bus outputs. Every transfer takes exactly three
    // cycles: setup (IDLE), one forced wait (WAIT), completion (DONE).
    always_comb begin
        state_nxt   = state;
        commit      = 1'b0;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata  = '0;
        case (state)
            S_IDLE: begin
                if (psel && !penable) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A master abandoning the transfer here leaves no side effect.
                if (!psel) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                commit      = 1'b1;
                apb.pready  = 1'b1;
                apb.pslverr = bad_access;
                apb.prdata  = rd_mux;
                state_nxt   = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Transmit side.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_o  <= '0;
            start_tx_o <= 1'b0;
            tx_busy    <= 1'b0;
        end else begin
            start_tx_o <= tx_accept;
            if (tx_accept) begin
                tx_data_o <= pwdata;
                tx_busy   <= 1'b1;
            end else if (tx_done_i) begin
                tx_busy <= 1'b0;
            end
        end
    end

    // Receive side. A new frame landing on the same cycle as the consuming
    // read is not an overrun: the host got the old word, the new one is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data          <= '0;
            rx_valid         <= 1'b0;
            host_read_data_o <= 1'b0;
        end else begin
            host_read_data_o <= rx_consume;
            if (rx_done_i) begin
                rx_data  <= rx_data_i;
                rx_valid <= 1'b1;
            end else if (rx_consume) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Sticky flags; a set event in the same cycle beats the W1C clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr    <= 1'b0;
            overrun <= 1'b0;
            txdrop  <= 1'b0;
        end else begin
            if (rx_done_i && parity_error_i) begin
                perr <= 1'b1;
            end else if (st_wr && pwdata[2]) begin
                perr <= 1'b0;
            end

            if (rx_done_i && rx_valid && !rx_consume) begin
                overrun <= 1'b1;
            end else if (st_wr && pwdata[3]) begin
                overrun <= 1'b0;
            end

            if (tx_drop) begin
                txdrop <= 1'b1;
            end else if (st_wr && pwdata[4]) begin
                txdrop <= 1'b0;
            end
        end
    end

    // Frame configuration and interrupt enables. No interlock against
    // changes mid-frame; the core sees new values immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg <= CFG_RST;
            ie  <= 2'b00;
        end else if (cfg_wr) begin
            cfg <= pwdata[4:0];
            ie  <= pwdata[6:5];
        end
    end

    assign data_bit_num_o = cfg[1:0];
    assign parity_en_o    = cfg[2];
    assign parity_type_o  = cfg[3];
    assign stop_bit_num_o = cfg[4];

    // Interrupt is registered from the current flag state, so it trails
    // any flag change by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= (ie[1] && rx_valid) || (ie[0] && !tx_busy) || perr || overrun;
        end
    end

endmodule

// File: tb/tb_uart_apb_regs.sv
// tb/tb_uart_apb_regs.sv - self-checking bench for uart_apb_regs
module tb_uart_apb_regs;

`ifdef UART_APB_PSLVERR_EN
    localparam logic PSLV = 1'b1;
`else
    localparam logic PSLV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tx_data_o;
    logic        start_tx_o;
    logic        tx_done_i;
    logic [31:0] rx_data_i;
    logic        rx_done_i;
    logic        parity_error_i;
    logic        host_read_data_o;
    logic [1:0]  data_bit_num_o;
    logic        parity_en_o;
    logic        parity_type_o;
    logic        stop_bit_num_o;
    logic        irq_o;

    always #5 clk = ~clk;

    uart_apb_regs_if #(.ADDR_W(4)) apb ();

    uart_apb_regs #(.ADDR_W(4), .CFG_RST(5'b00011)) dut (
        .clk              (clk),
        .rst              (rst),
        .apb              (apb),
        .tx_data_o        (tx_data_o),
        .start_tx_o       (start_tx_o),
        .tx_done_i        (tx_done_i),
        .rx_data_i        (rx_data_i),
        .rx_done_i        (rx_done_i),
        .parity_error_i   (parity_error_i),
        .host_read_data_o (host_read_data_o),
        .data_bit_num_o   (data_bit_num_o),
        .parity_en_o      (parity_en_o),
        .parity_type_o    (parity_type_o),
        .stop_bit_num_o   (stop_bit_num_o),
        .irq_o            (irq_o)
    );

    int total = 0;
    int bad   = 0;

    // Cycles each pulse output was seen high.
    int start_cnt = 0;
    int hread_cnt = 0;
    always @(negedge clk) begin
        if (start_tx_o) start_cnt++;
        if (host_read_data_o) hread_cnt++;
    end

    // Behavioural model of the register file, updated per completed transfer or core event.
    logic        m_busy, m_rv, m_perr, m_ovr, m_drop;
    logic [31:0] m_rxd, m_txd;
    logic [4:0]  m_cfg;
    logic [1:0]  m_ie;
    int          m_starts = 0;
    int          m_hreads = 0;

    task automatic model_reset();
        m_busy = 0; m_rv = 0; m_perr = 0; m_ovr = 0; m_drop = 0;
        m_rxd = 0; m_txd = 0; m_cfg = 5'b00011; m_ie = 2'b00;
    endtask

    function automatic logic [31:0] model_rd(input logic [3:0] a);
        case (a[3:2])
            2'd1:    return m_rxd;
            2'd2:    return {25'd0, m_ie, m_cfg};
            2'd3:    return {27'd0, m_drop, m_ovr, m_perr, m_rv, m_busy};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_irq();
        return (m_ie[1] & m_rv) | (m_ie[0] & ~m_busy) | m_perr | m_ovr;
    endfunction

    task automatic model_commit(input logic access, input logic wr, input logic [3:0] a,
                                input logic [31:0] wd, input logic txd, input logic rxd,
                                input logic [31:0] rxdat, input logic pe, output logic exp_err);
        logic acc;
        acc     = 0;
        exp_err = 0;
        if (access && !wr && a[3:2] == 2'd1 && m_rv) begin
            m_rv = 0;
            m_hreads++;
        end
        if (access && wr) begin
            case (a[3:2])
                2'd0: if (!m_busy || txd) acc = 1; else begin m_drop = 1; exp_err = PSLV; end
                2'd1: exp_err = PSLV;
                2'd2: begin m_cfg = wd[4:0]; m_ie = wd[6:5]; end
                default: begin
                    if (wd[2]) m_perr = 0;
                    if (wd[3]) m_ovr  = 0;
                    if (wd[4]) m_drop = 0;
                end
            endcase
        end
        if (txd) m_busy = 0;
        if (acc) begin m_busy = 1; m_txd = wd; m_starts++; end
        if (rxd) begin
            if (m_rv) m_ovr = 1;
            m_rv  = 1;
            m_rxd = rxdat;
            if (pe) m_perr = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One APB transfer; txd/rxd optionally pulse the core events during the DONE cycle.
    task automatic do_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                           input logic txd, input logic rxd, input logic [31:0] rxdat,
                           input logic rxpe, output logic [31:0] rdata);
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        err;
        int          lat;
        exp_rd = model_rd(addr);
        apb.psel = 1; apb.penable = 0; apb.pwrite = wr; apb.paddr = addr; apb.pwdata = wdata;
        tick();
        apb.penable = 1;
        lat = 2;
        while (apb.pready !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        rdata = apb.prdata;
        err   = apb.pslverr;
        tx_done_i = txd; rx_done_i = rxd; rx_data_i = rxdat; parity_error_i = rxpe;
        tick();
        apb.psel = 0; apb.penable = 0;
        tx_done_i = 0; rx_done_i = 0; parity_error_i = 0;
        model_commit(1'b1, wr, addr, wdata, txd, rxd, rxdat, rxpe, exp_err);
        check($sformatf("latency_%h", addr), 32'(lat), 32'd3);
        if (!wr) check($sformatf("prdata_%h", addr), rdata, exp_rd);
        check($sformatf("pslverr_%h_w%0d", addr, wr), 32'(err), 32'(exp_err));
    endtask

    task automatic wr_reg(input logic [3:0] addr, input logic [31:0] d);
        logic [31:0] unused_rd;
        do_xfer(1'b1, addr, d, 1'b0, 1'b0, 32'd0, 1'b0, unused_rd);
    endtask

    task automatic rd_reg(input logic [3:0] addr, output logic [31:0] d);
        do_xfer(1'b0, addr, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, d);
    endtask

    task automatic core_pulse(input logic txd, input logic rxd, input logic [31:0] d, input logic pe);
        logic unused_err;
        tx_done_i = txd; rx_done_i = rxd; rx_data_i = d; parity_error_i = pe;
        tick();
        tx_done_i = 0; rx_done_i = 0; parity_error_i = 0;
        model_commit(1'b0, 1'b0, 4'h0, 32'd0, txd, rxd, d, pe, unused_err);
    endtask

    task automatic check_state(input string tag);
        tick();
        check({tag, "_irq"},       32'(irq_o),          32'(model_irq()));
        check({tag, "_txdata"},    tx_data_o,           m_txd);
        check({tag, "_cfgout"},    {27'd0, stop_bit_num_o, parity_type_o, parity_en_o, data_bit_num_o},
                                   {27'd0, m_cfg});
        check({tag, "_starts"},    32'(start_cnt),      32'(m_starts));
        check({tag, "_hreads"},    32'(hread_cnt),      32'(m_hreads));
        check({tag, "_idle_bus"},  {apb.prdata[30:0], apb.pready}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        rst = 1; tx_done_i = 0; rx_done_i = 0; rx_data_i = 0; parity_error_i = 0;
        apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = 0; apb.pwdata = 0;
        model_reset();
        repeat (3) tick();
        rst = 0;

        // Reset state.
        check("rst_start", 32'(start_tx_o), 32'd0);
        check("rst_hread", 32'(host_read_data_o), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_pslverr", 32'(apb.pslverr), 32'd0);
        check_state("rst");
        rd_reg(4'h8, rd); check("cfg_rst", rd, 32'h3);
        rd_reg(4'hC, rd); check("status_rst", rd, 32'h0);

        // Single transmit.
        wr_reg(4'h0, 32'hA5);
        check_state("tx1");
        check("tx1_data", tx_data_o, 32'hA5);
        rd_reg(4'hC, rd); check("tx1_status", rd, 32'h1);
        core_pulse(1, 0, 0, 0);
        rd_reg(4'hC, rd); check("tx1_status_done", rd, 32'h0);

        // Second write while busy is dropped.
        wr_reg(4'h0, 32'h11);
        wr_reg(4'h0, 32'h22);
        check_state("txdrop");
        check("txdrop_data", tx_data_o, 32'h11);
        rd_reg(4'hC, rd); check("txdrop_status", rd, 32'h11);
        wr_reg(4'hC, 32'h10);
        rd_reg(4'hC, rd); check("txdrop_w1c", rd, 32'h1);
        core_pulse(1, 0, 0, 0);

        // Receive with parity error.
        core_pulse(0, 1, 32'h5C, 1);
        rd_reg(4'hC, rd); check("rx_status", rd, 32'h6);
        rd_reg(4'h4, rd); check("rx_data", rd, 32'h5C);
        check_state("rx");
        rd_reg(4'hC, rd); check("rx_status_after", rd, 32'h4);
        wr_reg(4'hC, 32'h4);

        // Overrun, then receive coinciding with the consuming read.
        core_pulse(0, 1, 32'h01, 0);
        core_pulse(0, 1, 32'h02, 0);
        rd_reg(4'hC, rd); check("ovr_status", rd, 32'hA);
        wr_reg(4'hC, 32'h8);
        do_xfer(1'b0, 4'h4, 32'd0, 1'b0, 1'b1, 32'h03, 1'b0, rd);
        check("coinc_rd", rd, 32'h02);
        rd_reg(4'hC, rd); check("coinc_status", rd, 32'h2);
        rd_reg(4'h4, rd); check("coinc_new", rd, 32'h03);
        check_state("coinc");

        // TXDATA write accepted thanks to tx_done_i in the same cycle.
        wr_reg(4'h0, 32'h33);
        do_xfer(1'b1, 4'h0, 32'h44, 1'b1, 1'b0, 32'd0, 1'b0, rd);
        check_state("txcoinc");
        check("txcoinc_data", tx_data_o, 32'h44);
        rd_reg(4'hC, rd); check("txcoinc_status", rd, 32'h1);
        core_pulse(1, 0, 0, 0);

        // Configuration register.
        wr_reg(4'h8, 32'hFFFF_FFFF);
        rd_reg(4'h8, rd); check("cfg_all", rd, 32'h7F);
        check_state("cfg_all");
        wr_reg(4'h9, 32'h1A);
        rd_reg(4'hB, rd); check("cfg_1a", rd, 32'h1A);
        check_state("cfg_1a");

        // Read of TXDATA, write to RXDATA.
        rd_reg(4'h0, rd); check("txdata_rd", rd, 32'h0);
        wr_reg(4'h4, 32'hDEAD);
        rd_reg(4'h4, rd); check("rxdata_ro", rd, 32'h03);

        // Random traffic against the model.
        for (int n = 0; n < 80; n++) begin
            int          op;
            logic [31:0] d, d2;
            logic        txd, rxd, pe;
            logic [3:0]  lo;
            op  = $urandom_range(0, 7);
            d   = $urandom;
            d2  = $urandom;
            txd = ($urandom_range(0, 3) == 0);
            rxd = ($urandom_range(0, 3) == 0);
            pe  = 1'($urandom_range(0, 1));
            lo  = 4'($urandom_range(0, 3));
            case (op)
                0: do_xfer(1'b1, 4'h0 | lo, d, txd, rxd, d2, pe, rd);
                1: core_pulse(1'b1, rxd, d2, pe);
                2: core_pulse(txd, 1'b1, d2, pe);
                3: do_xfer(1'b0, 4'h4 | lo, d, txd, rxd, d2, pe, rd);
                4: do_xfer(1'b0, 4'hC | lo, d, txd, rxd, d2, pe, rd);
                5: do_xfer(1'b1, 4'hC | lo, d, txd, rxd, d2, pe, rd);
                6: do_xfer(1'b1, 4'h8 | lo, d, txd, rxd, d2, pe, rd);
                default: do_xfer(1'b0, 4'h8 | lo, d, txd, rxd, d2, pe, rd);
            endcase
            if (n % 8 == 7) check_state("rand");
        end

        // Reset asserted in the WAIT cycle of a TXDATA write.
        wr_reg(4'h8, 32'h55);
        core_pulse(0, 1, 32'h77, 1);
        apb.psel = 1; apb.penable = 0; apb.pwrite = 1; apb.paddr = 4'h0; apb.pwdata = 32'h99;
        tick();
        apb.penable = 1;
        rst = 1;
        tick();
        rst = 0; apb.psel = 0; apb.penable = 0;
        model_reset();
        tick();
        check_state("midrst");
        rd_reg(4'hC, rd); check("midrst_status", rd, 32'h0);
        rd_reg(4'h8, rd); check("midrst_cfg", rd, 32'h3);
        check_state("midrst_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_apb_regs.md
Name: uart_apb_regs

Overview:
- APB3 slave register block on the host side of the UART core.
- Converts bus writes and reads into the core's control strobes: tx data plus start pulse, rx read acknowledge.
- Drives the frame configuration (data bits, parity, stop bits).
- Captures tx-done, rx-done and parity status into readable flags.
- Sits between the system APB fabric and uart_core; one instance per UART.

Parameters:
- ADDR_W, 4, width of paddr (byte address; bits [1:0] ignored).
- CFG_RST, 5'b00011, reset value of CFG[4:0] (8 data bits, no parity, 1 stop bit).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- psel  input  1  APB select.
- penable  input  1  APB enable.
- pwrite  input  1  APB write.
- paddr  input  ADDR_W  APB address.
- pwdata  input  32  APB write data.
- prdata  output  32  APB read data.
- pready  output  1  APB ready.
- pslverr  output  1  APB error.
- tx_data_o  output  32  data to core transmitter.
- start_tx_o  output  1  one-cycle transmit start pulse.
- tx_done_i  input  1  one-cycle pulse from core at end of frame.
- rx_data_i  input  32  received data from core.
- rx_done_i  input  1  one-cycle pulse from core, frame received.
- parity_error_i  input  1  parity status, valid with rx_done_i.
- host_read_data_o  output  1  one-cycle pulse, host consumed rx data.
- data_bit_num_o  output  2  CFG[1:0].
- parity_en_o  output  1  CFG[2].
- parity_type_o  output  1  CFG[3].
- stop_bit_num_o  output  1  CFG[4].
- irq_o  output  1  level interrupt.

Behaviour:
- Reset (sync, active-high; overrides everything including an in-flight transfer): all outputs 0 except config outputs = CFG_RST. tx_busy, rx_valid, sticky flags, IE = 0. FSM -> IDLE.
- APB FSM, states IDLE -> WAIT -> DONE -> IDLE:
  - IDLE: psel & !penable -> WAIT.
  - WAIT: one mandatory wait cycle, pready=0.
  - DONE: pready=1 for exactly one cycle; the register side effect commits on this cycle; -> IDLE.
  - psel dropping in WAIT -> IDLE, no side effect.
- prdata: valid only while pready=1; 0 otherwise.
- Register map:
  - 0x0 TXDATA (W): accepted if tx_busy==0, or tx_done_i is high in the same cycle.
    - Accept: tx_data_o<=pwdata, start_tx_o=1 next cycle for 1 cycle, tx_busy<=1.
    - Otherwise: write dropped, TXDROP<=1. Reads return 0.
  - 0x4 RXDATA (R): returns latched rx data.
    - If rx_valid=1: rx_valid<=0 and host_read_data_o pulses 1 cycle after DONE.
    - If rx_valid=0: returns stale data, no pulse. Writes ignored.
  - 0x8 CFG (RW): [4:0] as ports, [6:5] IE = {rx_ie, tx_ie}; other bits read 0. Changing CFG mid-frame is software's responsibility; no interlock.
  - 0xC STATUS: [0] tx_busy RO, [1] rx_valid RO, [2] PERR W1C, [3] OVERRUN W1C, [4] TXDROP W1C.
- tx_done_i clears tx_busy next cycle. tx_done_i with tx_busy=0 is ignored.
- rx_done_i: latches rx_data_i, sets rx_valid, PERR|=parity_error_i.
  - If rx_valid already 1 and not being cleared this cycle: OVERRUN<=1, data overwritten.
  - rx_done_i in the same cycle as an RXDATA read DONE: the read returns the old data, the new data is latched, rx_valid stays 1, no overrun.
- W1C and set in the same cycle: set wins.
- irq_o (registered) = (rx_ie & rx_valid) | (tx_ie & !tx_busy) | PERR | OVERRUN.

Optional Feature:
- Macro UART_APB_PSLVERR_EN.
- Defined: pslverr=1 in DONE for an unmapped address, a write to RXDATA, or a write to TXDATA that is dropped (TXDROP still set).
- Undefined: pslverr is tied 0 and those accesses complete silently.

Test Plan:
- Reset, then read CFG/STATUS -> 0x00000003 / 0x00000000; read shows pready high on the 3rd cycle of the transfer.
- Write 0xA5 to TXDATA -> tx_data_o=0xA5, single start_tx_o pulse, STATUS=0x1; tx_done_i pulse -> STATUS=0x0.
- Write 0x11 then 0x22 to TXDATA before tx_done_i -> tx_data_o stays 0x11, STATUS[4]=1 (pslverr=1 only with macro defined); write 0x10 to STATUS -> STATUS[4]=0.
- rx_done_i with rx_data_i=0x5C, parity_error_i=1 -> STATUS=0x6; read RXDATA returns 0x5C, one host_read_data_o pulse; STATUS=0x4.
- Two rx_done_i pulses without a read (0x01, 0x02) -> OVERRUN=1, RXDATA=0x02; rx_done_i with 0x03 coinciding with the RXDATA read DONE -> read returns 0x02, rx_valid stays 1.
- Assert rst during WAIT of a TXDATA write -> no start_tx_o, all flags 0, CFG=0x03.
